seq_alu: RTL and testbench

- Parametrised, clocked successor to the processor's combinational ALU.
- Performs single-cycle logic, arithmetic, shift and rotate operations, plus iterative signed multiply and divide.
- Uses a start/busy/done handshake and registered ZHI/ZLO outputs.
- Sits between the datapath operand registers (Ra, Rb) and the Z register pair; the control unit stalls on busy.

---
 rtl/alu_pkg.sv | 24 ++
 rtl/booth_mul_iter.sv | 62 ++++++
 rtl/seq_alu.sv | 180 ++++++++++++++++++
 tb/tb_seq_alu.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcode encodings and FSM states.
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_SHR  = 4'h2;
  localparam logic [3:0] OP_SHL  = 4'h3;
  localparam logic [3:0] OP_ROR  = 4'h4;
  localparam logic [3:0] OP_ROL  = 4'h5;
  localparam logic [3:0] OP_AND  = 4'h6;
  localparam logic [3:0] OP_OR   = 4'h7;
  localparam logic [3:0] OP_MUL  = 4'h8;
  localparam logic [3:0] OP_DIV  = 4'h9;
  localparam logic [3:0] OP_NEG  = 4'hA;
  localparam logic [3:0] OP_NOT  = 4'hB;
  localparam logic [3:0] OP_SHRA = 4'hC;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } state_t;

endpackage

// File: rtl/booth_mul_iter.sv
// Iterative signed radix-2 Booth multiplier datapath, one bit per step.
// The accumulator carries one guard bit so that subtracting the most
// negative multiplicand cannot overflow. next_hi/next_lo expose the
// product as it will be after the current step, so the owner can capture
// the final product on the same edge that completes the last step.
module booth_mul_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] multiplicand,
  input  logic [WIDTH-1:0] multiplier,
  output logic [WIDTH-1:0] next_hi,
  output logic [WIDTH-1:0] next_lo
);

  logic [WIDTH:0]   acc;
  logic [WIDTH:0]   mcand;
  logic [WIDTH-1:0] mq;
  logic             q_m1;

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   acc_next;
  logic [WIDTH-1:0] mq_next;

  // Booth recode of the current multiplier bit pair, then arithmetic shift right
  always_comb begin
    sum = acc;
    case ({mq[0], q_m1})
      2'b01:   sum = acc + mcand;
      2'b10:   sum = acc - mcand;
      default: sum = acc;
    endcase
    acc_next = {sum[WIDTH], sum[WIDTH:1]};
    mq_next  = {sum[0], mq[WIDTH-1:1]};
  end

  assign next_hi = acc_next[WIDTH-1:0];
  assign next_lo = mq_next;

  // Datapath registers: load clears the accumulator, step advances one bit
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      acc   <= '0;
      mcand <= '0;
      mq    <= '0;
      q_m1  <= 1'b0;
    end else if (load) begin
      acc   <= '0;
      mcand <= {multiplicand[WIDTH-1], multiplicand};
      mq    <= multiplier;
      q_m1  <= 1'b0;
    end else if (step) begin
      acc   <= acc_next;
      mq    <= mq_next;
      q_m1  <= mq[0];
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Clocked ALU with start/busy/done handshake. Logic, arithmetic, shift and
// rotate ops complete on the start edge; MUL and DIV iterate WIDTH cycles.
// ZHI/ZLO only change on a completion, so intermediate state never leaks.
module seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] Ra,
  input  logic [WIDTH-1:0] Rb,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] ZHI,
  output logic [WIDTH-1:0] ZLO
);

  state_t           state;
  logic [SHW-1:0]   iter_cnt;
  logic             last_iter;

  logic [SHW-1:0]     amt;
  logic [2*WIDTH-1:0] ror_ext;
  logic [2*WIDTH-1:0] rol_ext;
  logic [WIDTH-1:0]   sc_lo;

  logic             mul_load;
  logic             mul_step;
  logic [WIDTH-1:0] mul_hi;
  logic [WIDTH-1:0] mul_lo;

  logic [WIDTH-1:0] ra_mag;
  logic [WIDTH-1:0] rb_mag;
  logic [WIDTH-1:0] div_rem;
  logic [WIDTH-1:0] div_quo;
  logic [WIDTH-1:0] div_dvs;
  logic             div_qneg;
  logic             div_rneg;
  logic [WIDTH:0]   div_shift;
  logic             div_fit;
  logic [WIDTH-1:0] div_rem_next;
  logic [WIDTH-1:0] div_quo_next;
  logic [WIDTH-1:0] div_lo_final;
  logic [WIDTH-1:0] div_hi_final;

  assign last_iter = (iter_cnt == SHW'(WIDTH - 1));
  assign amt       = Rb[SHW-1:0];

  // Single-cycle results, computed straight from the live operands
  always_comb begin
    ror_ext = {Ra, Ra} >> amt;
    rol_ext = {Ra, Ra} << amt;
    sc_lo   = '0;
    case (op)
      OP_ADD:  sc_lo = Ra + Rb;
      OP_SUB:  sc_lo = Ra - Rb;
      OP_SHR:  sc_lo = Ra >> amt;
      OP_SHL:  sc_lo = Ra << amt;
      OP_ROR:  sc_lo = ror_ext[WIDTH-1:0];
      OP_ROL:  sc_lo = rol_ext[2*WIDTH-1:WIDTH];
      OP_AND:  sc_lo = Ra & Rb;
      OP_OR:   sc_lo = Ra | Rb;
      OP_NEG:  sc_lo = -Rb;
      OP_NOT:  sc_lo = ~Rb;
      OP_SHRA: sc_lo = $signed(Ra) >>> amt;
      default: sc_lo = '0;
    endcase
  end

  assign mul_load = (state == ST_IDLE) && start && (op == OP_MUL);
  assign mul_step = (state == ST_MUL);

  booth_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clock        (clock),
    .reset_n      (reset_n),
    .load         (mul_load),
    .step         (mul_step),
    .multiplicand (Ra),
    .multiplier   (Rb),
    .next_hi      (mul_hi),
    .next_lo      (mul_lo)
  );

  assign ra_mag = Ra[WIDTH-1] ? -Ra : Ra;
  assign rb_mag = Rb[WIDTH-1] ? -Rb : Rb;

  // One restoring-divide step on magnitudes, plus sign fix-up of the final result
  always_comb begin
    div_shift    = {div_rem, div_quo[WIDTH-1]};
    div_fit      = (div_shift >= {1'b0, div_dvs});
    div_rem_next = div_fit ? WIDTH'(div_shift - {1'b0, div_dvs}) : div_shift[WIDTH-1:0];
    div_quo_next = {div_quo[WIDTH-2:0], div_fit};
    div_lo_final = div_qneg ? -div_quo_next : div_quo_next;
    div_hi_final = div_rneg ? -div_rem_next : div_rem_next;
  end

  // Control FSM with registered handshake and result outputs
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      iter_cnt <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      ZHI      <= '0;
      ZLO      <= '0;
      div_rem  <= '0;
      div_quo  <= '0;
      div_dvs  <= '0;
      div_qneg <= 1'b0;
      div_rneg <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            div_zero <= 1'b0;
            if (op == OP_MUL) begin
              state    <= ST_MUL;
              busy     <= 1'b1;
              iter_cnt <= '0;
            end else if (op == OP_DIV && Rb != '0) begin
              state    <= ST_DIV;
              busy     <= 1'b1;
              iter_cnt <= '0;
              div_rem  <= '0;
              div_quo  <= ra_mag;
              div_dvs  <= rb_mag;
              div_qneg <= Ra[WIDTH-1] ^ Rb[WIDTH-1];
              div_rneg <= Ra[WIDTH-1];
            end else if (op == OP_DIV) begin
              ZLO      <= '1;
              ZHI      <= Ra;
              div_zero <= 1'b1;
              done     <= 1'b1;
            end else begin
              ZLO  <= sc_lo;
              ZHI  <= '0;
              done <= 1'b1;
            end
          end
        end
        ST_MUL: begin
          if (last_iter) begin
            ZHI   <= mul_hi;
            ZLO   <= mul_lo;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= ST_IDLE;
          end else begin
            iter_cnt <= iter_cnt + 1'b1;
          end
        end
        ST_DIV: begin
          div_rem <= div_rem_next;
          div_quo <= div_quo_next;
          if (last_iter) begin
            ZHI   <= div_hi_final;
            ZLO   <= div_lo_final;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= ST_IDLE;
          end else begin
            iter_cnt <= iter_cnt + 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu: a 32-bit and an 8-bit instance, a
// reference model feeding scoreboard queues, and monitors that pop and
// compare whenever done pulses.
module tb_seq_alu;
  import alu_pkg::*;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          lat;
    int          done_edge;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset_n;

  logic        start, busy, done, div_zero;
  logic [3:0]  op;
  logic [31:0] ra, rb, zhi, zlo;

  logic        start8, busy8, done8, div_zero8;
  logic [3:0]  op8;
  logic [7:0]  ra8, rb8, zhi8, zlo8;

  int   errors = 0;
  int   checks = 0;
  int   edge_cnt = 0;
  exp_t exp_q[$];
  exp_t exp8_q[$];
  exp_t e32, e8;

  always #5 clock = ~clock;

  seq_alu #(.WIDTH(32)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .op(op), .Ra(ra), .Rb(rb),
    .busy(busy), .done(done), .div_zero(div_zero), .ZHI(zhi), .ZLO(zlo)
  );

  seq_alu #(.WIDTH(8)) dut8 (
    .clock(clock), .reset_n(reset_n), .start(start8), .op(op8), .Ra(ra8), .Rb(rb8),
    .busy(busy8), .done(done8), .div_zero(div_zero8), .ZHI(zhi8), .ZLO(zlo8)
  );

  // Count rising edges so completion latency can be checked
  always @(posedge clock) edge_cnt <= edge_cnt + 1;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  // Reference model built on the language's own signed arithmetic
  function automatic exp_t model(input int w, input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    logic [63:0] mask, ua, ub, r64;
    longint      sa, sb, p;
    int          amt;
    mask = (64'd1 << w) - 64'd1;
    ua = {32'd0, a} & mask;
    ub = {32'd0, b} & mask;
    sa = longint'(ua);
    if (ua[w-1]) sa = sa - longint'(64'd1 << w);
    sb = longint'(ub);
    if (ub[w-1]) sb = sb - longint'(64'd1 << w);
    amt = int'(ub[4:0]) & (w - 1);
    e.hi = '0; e.lo = '0; e.dz = 1'b0; e.lat = 0; e.done_edge = 0;
    r64 = '0;
    case (o)
      OP_ADD:  r64 = ua + ub;
      OP_SUB:  r64 = ua - ub;
      OP_SHR:  r64 = ua >> amt;
      OP_SHL:  r64 = ua << amt;
      OP_ROR:  r64 = (ua >> amt) | (ua << (w - amt));
      OP_ROL:  r64 = (ua << amt) | (ua >> (w - amt));
      OP_AND:  r64 = ua & ub;
      OP_OR:   r64 = ua | ub;
      OP_NEG:  r64 = 64'd0 - ub;
      OP_NOT:  r64 = ~ub;
      OP_SHRA: r64 = 64'(sa >>> amt);
      OP_MUL: begin
        p     = sa * sb;
        r64   = 64'(p);
        e.hi  = 32'((64'(p) >> w) & mask);
        e.lat = w;
      end
      OP_DIV: begin
        if (sb == 0) begin
          r64  = mask;
          e.hi = 32'(ua);
          e.dz = 1'b1;
        end else begin
          r64   = 64'(sa / sb);
          e.hi  = 32'(64'(sa % sb) & mask);
          e.lat = w;
        end
      end
      default: r64 = '0;
    endcase
    e.lo = 32'(r64 & mask);
    return e;
  endfunction

  // Drive one start at a negedge, push the expected result, release start
  task automatic applyStimulus(input bit is8, input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    e = model(is8 ? 8 : 32, o, a, b);
    e.done_edge = edge_cnt + 1 + e.lat;
    if (is8) begin
      start8 = 1'b1; op8 = o; ra8 = a[7:0]; rb8 = b[7:0];
      exp8_q.push_back(e);
    end else begin
      start = 1'b1; op = o; ra = a; rb = b;
      exp_q.push_back(e);
    end
    @(negedge clock);
    if (is8) start8 = 1'b0;
    else     start  = 1'b0;
  endtask

  // Wait for an iterative op to finish, optionally hammering start meanwhile
  task automatic waitForIdle(input bit is8, input bit noise);
    int cycles = 0;
    bit seen_idle = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (!(is8 ? busy8 : busy)) begin
        seen_idle = 1'b1;
        break;
      end
      cycles++;
      if (noise) begin
        start = 1'b1;
        op = 4'($urandom_range(0, 12));
        ra = $urandom;
        rb = $urandom;
      end
      @(negedge clock);
    end
    start = 1'b0;
    checkOutput("idle_reached", 64'(seen_idle), 64'd1);
    checkOutput("busy_cycles", 64'(cycles), is8 ? 64'd8 : 64'd32);
  endtask

  // Scoreboard for the 32-bit instance
  always @(negedge clock) begin
    if (reset_n) begin
      checkOutput("done_busy_excl", 64'(done & busy), 64'd0);
      if (done) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_done", 64'd1, 64'd0);
        end else begin
          e32 = exp_q.pop_front();
          checkOutput("zlo", 64'(zlo), 64'(e32.lo));
          checkOutput("zhi", 64'(zhi), 64'(e32.hi));
          checkOutput("div_zero", 64'(div_zero), 64'(e32.dz));
          checkOutput("done_edge", 64'(edge_cnt), 64'(e32.done_edge));
        end
      end
    end
  end

  // Scoreboard for the 8-bit instance
  always @(negedge clock) begin
    if (reset_n) begin
      checkOutput("done_busy_excl8", 64'(done8 & busy8), 64'd0);
      if (done8) begin
        if (exp8_q.size() == 0) begin
          checkOutput("unexpected_done8", 64'd1, 64'd0);
        end else begin
          e8 = exp8_q.pop_front();
          checkOutput("zlo8", 64'(zlo8), 64'(e8.lo));
          checkOutput("zhi8", 64'(zhi8), 64'(e8.hi));
          checkOutput("div_zero8", 64'(div_zero8), 64'(e8.dz));
          checkOutput("done_edge8", 64'(edge_cnt), 64'(e8.done_edge));
        end
      end
    end
  end

  // Hard time limit so the run always ends
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [3:0] o;
    reset_n = 1'b0;
    start = 1'b0; op = '0; ra = '0; rb = '0;
    start8 = 1'b0; op8 = '0; ra8 = '0; rb8 = '0;
    repeat (2) @(negedge clock);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_done", 64'(done), 64'd0);
    checkOutput("rst_div_zero", 64'(div_zero), 64'd0);
    checkOutput("rst_zhi", 64'(zhi), 64'd0);
    checkOutput("rst_zlo", 64'(zlo), 64'd0);
    checkOutput("rst_z8", 64'({zhi8, zlo8}), 64'd0);
    reset_n = 1'b1;
    @(negedge clock);

    $display("[TB] single-cycle ADD overflow wrap");
    applyStimulus(1'b0, OP_ADD, 32'h7FFF_FFFF, 32'h1);
    checkOutput("add_busy", 64'(busy), 64'd0);
    checkOutput("add_done", 64'(done), 64'd1);
    checkOutput("add_zlo", 64'(zlo), 64'h8000_0000);

    $display("[TB] MUL with ignored start pulses");
    applyStimulus(1'b0, OP_MUL, 32'hFFFF_FFFD, 32'h5);
    waitForIdle(1'b0, 1'b1);
    checkOutput("mul_prod", {zhi, zlo}, 64'hFFFF_FFFF_FFFF_FFF1);

    $display("[TB] DIV signed and divide by zero");
    applyStimulus(1'b0, OP_DIV, 32'hFFFF_FFF9, 32'h2);
    waitForIdle(1'b0, 1'b0);
    checkOutput("div_result", {zhi, zlo}, 64'hFFFF_FFFF_FFFF_FFFD);
    applyStimulus(1'b0, OP_DIV, 32'h7, 32'h0);
    checkOutput("div0_flag", 64'(div_zero), 64'd1);
    checkOutput("div0_result", {zhi, zlo}, 64'h0000_0007_FFFF_FFFF);

    $display("[TB] shifts and rotates");
    applyStimulus(1'b0, OP_ROR, 32'h1, 32'h21);
    checkOutput("ror_zlo", 64'(zlo), 64'h8000_0000);
    checkOutput("div0_cleared", 64'(div_zero), 64'd0);
    applyStimulus(1'b0, OP_SHRA, 32'h8000_0000, 32'h4);
    checkOutput("shra_zlo", 64'(zlo), 64'hF800_0000);
    applyStimulus(1'b0, OP_ROL, 32'h1234_5678, 32'h0);
    checkOutput("rol0_zlo", 64'(zlo), 64'h1234_5678);

    $display("[TB] back-to-back single-cycle burst");
    for (int i = 0; i < 40; i++) begin
      o = 4'($urandom_range(0, 15));
      if (o == OP_MUL || o == OP_DIV) o = OP_SUB;
      applyStimulus(1'b0, o, $urandom, $urandom);
    end

    $display("[TB] iterative corner cases");
    applyStimulus(1'b0, OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    waitForIdle(1'b0, 1'b0);
    checkOutput("div_min_m1", {zhi, zlo}, 64'h0000_0000_8000_0000);
    applyStimulus(1'b0, OP_MUL, 32'h8000_0000, 32'h8000_0000);
    waitForIdle(1'b0, 1'b0);
    checkOutput("mul_min_min", {zhi, zlo}, 64'h4000_0000_0000_0000);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b0, (i % 2 == 0) ? OP_MUL : OP_DIV, $urandom, $urandom_range(1, 32'hFFFF_FFFF));
      waitForIdle(1'b0, 1'b0);
    end

    $display("[TB] asynchronous abort mid DIV");
    applyStimulus(1'b0, OP_DIV, 32'h0001_2345, 32'h7);
    repeat (9) @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("abort_busy", 64'(busy), 64'd0);
    checkOutput("abort_done", 64'(done), 64'd0);
    checkOutput("abort_z", {zhi, zlo}, 64'd0);
    exp_q.delete();
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    applyStimulus(1'b0, OP_ADD, 32'h5, 32'h6);
    checkOutput("post_abort_add", 64'(zlo), 64'hB);

    $display("[TB] 8-bit instance");
    applyStimulus(1'b1, OP_MUL, 32'h80, 32'hFF);
    waitForIdle(1'b1, 1'b0);
    checkOutput("mul8", 64'({zhi8, zlo8}), 64'h0080);
    applyStimulus(1'b1, OP_DIV, 32'h80, 32'hFF);
    waitForIdle(1'b1, 1'b0);
    checkOutput("div8", 64'({zhi8, zlo8}), 64'h0080);
    applyStimulus(1'b1, OP_DIV, 32'h5A, 32'h0);
    checkOutput("div8_zero", 64'(div_zero8), 64'd1);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, (i % 2 == 0) ? OP_DIV : OP_MUL, $urandom, $urandom_range(1, 255));
      waitForIdle(1'b1, 1'b0);
    end
    applyStimulus(1'b1, OP_ROR, 32'h01, 32'h09);

    repeat (3) @(negedge clock);
    checkOutput("queue_empty", 64'(exp_q.size()), 64'd0);
    checkOutput("queue8_empty", 64'(exp8_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
